axis_pkt_arbiter: RTL and testbench
===================================

# axis_pkt_arbiter

Packet-level round-robin arbiter that shares one AXI-Stream egress (for example, the input of a buffering FIFO or the LBUS converter) between NUM_PORTS requesting streams. A grant is held from the first beat to the `tlast` beat of a packet, so packets are never interleaved. The output is registered with ready/valid backpressure, so the block sits directly in front of the shared datapath without an extra skid stage.

## Interface
- `NUM_PORTS`, default 4: number of requesting streams, minimum 2.
- `DWIDTH`, default 512: data width in bits, a multiple of 8.
- `KWIDTH`, default DWIDTH/8: `tkeep` width.
- `IDX_W`, default $clog2(NUM_PORTS): width of the port index.
- `clk`, in, 1: single clock for all logic.
- `rst_n`, in, 1: synchronous reset, active-low.
- `s_axis_tdata`, in, NUM_PORTS*DWIDTH: input data; port i occupies slice i.
- `s_axis_tkeep`, in, NUM_PORTS*KWIDTH: per-port byte enables.
- `s_axis_tlast`, in, NUM_PORTS: per-port end of packet.
- `s_axis_tvalid`, in, NUM_PORTS: per-port valid.
- `s_axis_tready`, out, NUM_PORTS: per-port ready.
- `m_axis_tdata`, out, DWIDTH: granted data, registered.
- `m_axis_tkeep`, out, KWIDTH: registered.
- `m_axis_tlast`, out, 1: registered.
- `m_axis_tvalid`, out, 1: registered.
- `m_axis_tready`, in, 1: downstream ready.
- `m_axis_tid`, out, IDX_W: source port of the current output beat. Present only with `AXIS_ARB_TID_EN`.
- `busy`, out, 1: high while in PASS.

## Operation
- The FSM has two states, IDLE and PASS. Registers are `state`, `grant` (IDX_W), and `last_grant` (IDX_W).
- IDLE: if any `s_axis_tvalid` is high, pick the first requester searching from `last_grant+1` upward, wrapping from NUM_PORTS-1 to 0. Register it into `grant` and go to PASS. All `s_axis_tready` are 0 in IDLE.
- PASS: `s_axis_tready[grant] = core_rdy`, where `core_rdy = m_axis_tready | ~m_axis_tvalid`. All other `s_axis_tready` are 0.
- A beat is accepted when `s_axis_tvalid[grant] & core_rdy`. The output registers then load that port's data, keep and last, with `m_axis_tvalid` set to 1.
- If `core_rdy` is high and no beat is accepted, `m_axis_tvalid` clears to 0.
- When the accepted beat has `tlast` set: `last_grant <= grant` and the FSM returns to IDLE.
- Round-robin rule: the port that just finished has the lowest priority in the next arbitration.
- A granted port that drops `tvalid` mid-packet keeps the grant indefinitely. No timeout is applied.
- Requests that arrive or go away while in PASS have no effect until the FSM is back in IDLE.
- `grant` is stable for the whole packet.

## Timing
- Reset (`rst_n` = 0 at a clock edge) forces: state IDLE, `grant` = 0, `last_grant` = NUM_PORTS-1 (so port 0 wins first), `m_axis_tvalid`/`tlast`/`tdata`/`tkeep` = 0, `m_axis_tid` = 0, `busy` = 0, all `s_axis_tready` = 0.
- Reset mid-packet: the partial packet is abandoned and no `tlast` is emitted. The requester is responsible for any resend.
- Latency: `tvalid` seen in IDLE at cycle 0, so `grant` is registered at cycle 1 and the first beat is on `m_axis` at cycle 2.
- Each subsequent beat takes one cycle.
- There is exactly one bubble cycle (IDLE) between consecutive packets.
- Throughput is 1 beat/cycle inside a packet while `m_axis_tready` = 1.
- Output holds data stable while `m_axis_tvalid & ~m_axis_tready`, per AXI-Stream rules.
- Single-beat packet (`tlast` on the first beat): PASS lasts one cycle, then IDLE.

## Configuration
- `AXIS_ARB_TID_EN` defined: a `tid` output register is compiled in. It is loaded with `grant` alongside the data, and `m_axis_tid` is exposed.
- `AXIS_ARB_TID_EN` undefined: the `m_axis_tid` port and its register are absent, and all other behaviour is identical.

## Structure
- Package `axis_arb_pkg`: the `arb_state_t` enum (IDLE, PASS) and a `RR_NONE` constant.
- Sub-module `axis_rr_pick`: a combinational round-robin priority encoder.
  - Inputs: `req[NUM_PORTS]`, `last[IDX_W]`.
  - Outputs: `idx[IDX_W]`, `any`.
  - The top level instantiates it once.

## Test plan
- **Port 0 alone:** after reset, port 0 sends a 3-beat packet (data 0xA0..0xA2), `m_axis_tready` = 1. Expect the first output beat 2 cycles after `tvalid`, beats 0xA0, 0xA1, 0xA2 with `tlast` on 0xA2, and `busy` low one cycle later.
- **All ports requesting:** all 4 ports continuously send 2-beat packets. Expect output packet sources in the order 0, 1, 2, 3, 0, with one idle cycle between packets and no interleaving.
- **Backpressure:** `m_axis_tready` toggles 1,0,0,1 during a granted packet. Expect output beats held stable while ready = 0, no beat lost or duplicated, and the granted port's `tready` tracking `core_rdy`.
- **Late requester:** port 1 is mid-packet when port 0 raises `tvalid`. Port 1 keeps the grant until its `tlast`. Next, port 2 and port 0 request together; expect port 2 to win (searching from `last_grant` = 1).
- **Reset mid-packet:** `rst_n` pulses low for one cycle after beat 2 of a 5-beat packet. Expect `m_axis_tvalid` = 0, all `s_axis_tready` = 0, and the next grant going to port 0.
- **`AXIS_ARB_TID_EN` build:** `m_axis_tid` equals the source index on every beat (for example 3 for port 3), and is stable under backpressure.

Source files
------------

// File: rtl/axis_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axis_arb_pkg                                               |
// | Purpose  : Shared types and constants for the packet arbiter.         |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package axis_arb_pkg;

  // Arbiter FSM: IDLE arbitrates, PASS forwards one whole packet.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PASS = 1'b1
  } arb_state_t;

  // Index reported by the picker when nobody is requesting.
  localparam int RR_NONE = 0;

endpackage
`default_nettype wire

// File: rtl/axis_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axis_rr_pick                                               |
// | Purpose  : Combinational round-robin priority encoder. The search     |
// |            starts at the port after `last` and wraps, so `last`       |
// |            itself has the lowest priority.                            |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module axis_rr_pick
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  logic [IDX_W-1:0] w_cand;

  // Walk the ports in rotated order and keep the first requester found.
  always_comb begin
    idx    = IDX_W'(RR_NONE);
    any    = 1'b0;
    w_cand = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_cand = IDX_W'((int'(last) + k) % NUM_PORTS);
      if (!any && req[w_cand]) begin
        idx = w_cand;
        any = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : axis_pkt_arbiter                                           |
// | Purpose  : Packet-level round-robin arbiter sharing one AXI-Stream    |
// |            egress between NUM_PORTS streams. A grant is held from     |
// |            the first beat to tlast; the output stage is registered    |
// |            with ready/valid backpressure.                             |
// | Options  : AXIS_ARB_TID_EN - adds the registered m_axis_tid output.   |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module axis_pkt_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DWIDTH    = 512,
  parameter int KWIDTH    = DWIDTH / 8,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS*DWIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*KWIDTH-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]        s_axis_tlast,
  input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
  output logic [NUM_PORTS-1:0]        s_axis_tready,
  output logic [DWIDTH-1:0]           m_axis_tdata,
  output logic [KWIDTH-1:0]           m_axis_tkeep,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
`ifdef AXIS_ARB_TID_EN
  output logic [IDX_W-1:0]            m_axis_tid,
`endif
  output logic                        busy
);

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_last_grant;
  logic             r_busy;
  logic             r_tvalid;
  logic             r_tlast;
  logic [DWIDTH-1:0] r_tdata;
  logic [KWIDTH-1:0] r_tkeep;
`ifdef AXIS_ARB_TID_EN
  logic [IDX_W-1:0] r_tid;
`endif

  logic [IDX_W-1:0]  w_pick;
  logic              w_any;
  logic              w_core_rdy;
  logic              w_accept;
  logic              w_sel_valid;
  logic              w_sel_last;
  logic [DWIDTH-1:0] w_sel_data;
  logic [KWIDTH-1:0] w_sel_keep;

  logic [DWIDTH-1:0] w_data [NUM_PORTS];
  logic [KWIDTH-1:0] w_keep [NUM_PORTS];

  // Split the flat input buses into per-port slices.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign w_data[gi] = s_axis_tdata[gi*DWIDTH +: DWIDTH];
      assign w_keep[gi] = s_axis_tkeep[gi*KWIDTH +: KWIDTH];
    end
  endgenerate

  axis_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_pick (
    .req  (s_axis_tvalid),
    .last (r_last_grant),
    .idx  (w_pick),
    .any  (w_any)
  );

  // The output register can take a new beat when empty or being drained.
  assign w_core_rdy  = m_axis_tready | ~r_tvalid;
  assign w_sel_valid = s_axis_tvalid[r_grant];
  assign w_sel_last  = s_axis_tlast[r_grant];
  assign w_sel_data  = w_data[r_grant];
  assign w_sel_keep  = w_keep[r_grant];
  assign w_accept    = (r_state == PASS) & w_sel_valid & w_core_rdy;

  // Only the granted port sees ready, and only while forwarding a packet.
  always_comb begin
    s_axis_tready = '0;
    if (r_state == PASS) begin
      s_axis_tready[r_grant] = w_core_rdy;
    end
  end

  // Arbitration FSM together with the registered output stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_PORTS - 1);
      r_busy       <= 1'b0;
      r_tvalid     <= 1'b0;
      r_tlast      <= 1'b0;
      r_tdata      <= '0;
      r_tkeep      <= '0;
`ifdef AXIS_ARB_TID_EN
      r_tid        <= '0;
`endif
    end else begin
      if (w_accept) begin
        r_tvalid <= 1'b1;
        r_tlast  <= w_sel_last;
        r_tdata  <= w_sel_data;
        r_tkeep  <= w_sel_keep;
`ifdef AXIS_ARB_TID_EN
        r_tid    <= r_grant;
`endif
      end else if (w_core_rdy) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_state <= PASS;
            r_busy  <= 1'b1;
          end
        end
        PASS: begin
          if (w_accept && w_sel_last) begin
            r_last_grant <= r_grant;
            r_state      <= IDLE;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tkeep  = r_tkeep;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tvalid = r_tvalid;
  assign busy          = r_busy;
`ifdef AXIS_ARB_TID_EN
  assign m_axis_tid    = r_tid;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_axis_pkt_arbiter                                        |
// | Purpose  : Self-checking bench for axis_pkt_arbiter: directed         |
// |            scenarios plus randomized traffic against a packet-level   |
// |            reference model. Honours AXIS_ARB_TID_EN.                  |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_axis_pkt_arbiter;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  wire  [NP*DW-1:0] s_tdata;
  wire  [NP*KW-1:0] s_tkeep;
  wire  [NP-1:0]    s_tlast;
  wire  [NP-1:0]    s_tvalid;
  wire  [NP-1:0]    s_tready;
  wire  [DW-1:0]    m_tdata;
  wire  [KW-1:0]    m_tkeep;
  wire              m_tlast;
  wire              m_tvalid;
  logic             m_tready;
  wire              busy;
`ifdef AXIS_ARB_TID_EN
  wire  [IW-1:0]    m_tid;
`endif

  always #5 clk = ~clk;

  axis_pkt_arbiter #(
    .NUM_PORTS (NP),
    .DWIDTH    (DW),
    .KWIDTH    (KW),
    .IDX_W     (IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tlast  (m_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
`ifdef AXIS_ARB_TID_EN
    .m_axis_tid    (m_tid),
`endif
    .busy          (busy)
  );

  // Per-port source drive, packed onto the flat buses.
  logic          v_a [NP];
  logic          l_a [NP];
  logic [DW-1:0] d_a [NP];
  logic [KW-1:0] k_a [NP];
  logic          rdy_a [NP];
  logic          hs [NP];

  generate
    for (genvar g = 0; g < NP; g++) begin : g_pack
      assign s_tvalid[g]          = v_a[g];
      assign s_tlast[g]           = l_a[g];
      assign s_tdata[g*DW +: DW]  = d_a[g];
      assign s_tkeep[g*KW +: KW]  = k_a[g];
      assign rdy_a[g]             = s_tready[g];
    end
  endgenerate

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- source engine ----------------
  int q_len  [NP][$];
  int q_base [NP][$];
  int beat   [NP];
  int prob     = 100;
  bit rdy_rand = 1'b0;
  int rdy_script[$];
  int tot_beats = 0;

  task automatic push(input int p, input int len, input int base);
    q_len[p].push_back(len);
    q_base[p].push_back(base);
    tot_beats += len;
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      v_a[p] = 1'b0; l_a[p] = 1'b0; d_a[p] = '0; k_a[p] = '0; beat[p] = 0; hs[p] = 1'b0;
    end
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (hs[p] && q_len[p].size() > 0) begin
          beat[p]++;
          if (beat[p] >= q_len[p][0]) begin
            void'(q_len[p].pop_front());
            void'(q_base[p].pop_front());
            beat[p] = 0;
          end
        end
        if (q_len[p].size() > 0 && int'($urandom_range(99)) < prob) begin
          v_a[p] = 1'b1;
          d_a[p] = DW'(q_base[p][0] + beat[p]);
          k_a[p] = KW'(q_base[p][0] + beat[p]) | KW'(1);
          l_a[p] = (beat[p] == q_len[p][0] - 1);
        end else begin
          v_a[p] = 1'b0;
          l_a[p] = 1'b0;
        end
      end
      if (rdy_script.size() > 0) m_tready = (rdy_script.pop_front() != 0);
      else if (rdy_rand)         m_tready = ($urandom_range(99) < 70);
      else                       m_tready = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  // Owner is the port whose packet is in flight (-1 between packets);
  // the output slot holds the most recent beat until drained.
  int            mo_owner = -1;
  int            mo_lastg = NP - 1;
  logic          mo_v = 1'b0;
  logic          mo_l = 1'b0;
  logic [DW-1:0] mo_d = '0;
  logic [KW-1:0] mo_k = '0;
  int            mo_tid = 0;
  logic          mo_room;
  int            mo_next;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      mo_owner = -1; mo_lastg = NP - 1;
      mo_v = 1'b0; mo_l = 1'b0; mo_d = '0; mo_k = '0; mo_tid = 0;
      chk_en = 1'b1;
    end else begin
      mo_room = m_tready || !mo_v;
      mo_next = mo_owner;
      if (mo_owner < 0) begin
        for (int k = 1; k <= NP; k++) begin
          if (mo_next < 0 && v_a[(mo_lastg + k) % NP]) mo_next = (mo_lastg + k) % NP;
        end
        if (mo_room) mo_v = 1'b0;
      end else if (v_a[mo_owner] && mo_room) begin
        mo_v = 1'b1; mo_d = d_a[mo_owner]; mo_k = k_a[mo_owner];
        mo_l = l_a[mo_owner]; mo_tid = mo_owner;
        if (l_a[mo_owner]) begin
          mo_lastg = mo_owner;
          mo_next  = -1;
        end
      end else if (mo_room) begin
        mo_v = 1'b0;
      end
      mo_owner = mo_next;
    end
  end

  // ---------------- compare + monitor ----------------
  logic [DW-1:0] out_data[$];
  logic          out_last[$];
  int            out_src[$];
  bit            in_pkt = 1'b0;
  int            t_first_v = -1;
  int            t_first_m = -1;
  logic          tl_busy = 1'b1;
  logic [NP-1:0] exp_rdy;

  initial forever begin
    @(negedge clk);
    for (int p = 0; p < NP; p++) hs[p] = rst_n && v_a[p] && rdy_a[p];
    if (chk_en) begin
      exp_rdy = '0;
      if (mo_owner >= 0) exp_rdy = NP'(m_tready || !mo_v) << mo_owner;
      chk("m_tvalid", m_tvalid, mo_v);
      if (mo_v) begin
        chk("m_tdata", m_tdata, mo_d);
        chk("m_tkeep", m_tkeep, mo_k);
        chk("m_tlast", m_tlast, mo_l);
`ifdef AXIS_ARB_TID_EN
        chk("m_tid", m_tid, mo_tid);
`endif
      end
      chk("busy", busy, mo_owner >= 0);
      chk("s_tready", s_tready, exp_rdy);
    end
    if (!rst_n) begin
      in_pkt = 1'b0;
    end else begin
      if (t_first_v < 0 && v_a[0]) t_first_v = cyc;
      if (t_first_m < 0 && m_tvalid) t_first_m = cyc;
      if (m_tvalid && m_tready) begin
        if (!in_pkt) out_src.push_back(int'(m_tdata[11:8]));
        out_data.push_back(m_tdata);
        out_last.push_back(m_tlast);
        in_pkt = !m_tlast;
        if (m_tlast) tl_busy = busy;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic clear_logs();
    out_data.delete(); out_last.delete(); out_src.delete();
    t_first_v = -1; t_first_m = -1; tot_beats = 0; tl_busy = 1'b1;
  endtask

  function automatic bit all_idle();
    bit e = 1'b1;
    for (int p = 0; p < NP; p++) if (q_len[p].size() != 0) e = 1'b0;
    return e && !busy && !m_tvalid;
  endfunction

  task automatic wait_idle(input string name, input int bound);
    int n = 0;
    while (!all_idle() && n < bound) begin tick(); n++; end
    chk({"drain ", name}, all_idle(), 1);
  endtask

  task automatic wait_busy(input string name, input int bound);
    int n = 0;
    while (!busy && n < bound) begin tick(); n++; end
    chk({"grant ", name}, busy, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    for (int p = 0; p < NP; p++) beat[p] = 0;
    clear_logs();
  endtask

  int exp2 [5] = '{0, 1, 2, 3, 0};
  int exp4 [3] = '{1, 2, 0};
  int n_wait;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("reset m_tvalid", m_tvalid, 0);
    chk("reset m_tdata", m_tdata, 0);
    chk("reset m_tkeep", m_tkeep, 0);
    chk("reset m_tlast", m_tlast, 0);
    chk("reset s_tready", s_tready, 0);
    chk("reset busy", busy, 0);
`ifdef AXIS_ARB_TID_EN
    chk("reset m_tid", m_tid, 0);
`endif

    // Port 0 alone, 3 beats
    clear_logs();
    push(0, 3, 'hA0);
    wait_idle("t1", 100);
    chk("t1 latency", 64'(t_first_m - t_first_v), 2);
    chk("t1 beat count", out_data.size(), 3);
    for (int i = 0; i < 3; i++) begin
      chk("t1 data", (i < out_data.size()) ? out_data[i] : 'hDEAD, 'hA0 + i);
      chk("t1 last", (i < out_last.size()) ? out_last[i] : 1'bx, i == 2);
    end
    chk("t1 busy at tlast", tl_busy, 0);

    // All ports requesting, 2-beat packets
    do_reset();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < NP; p++) push(p, 2, (p << 8) | (k << 4));
    wait_idle("t2", 300);
    chk("t2 packet count", out_src.size(), 8);
    for (int i = 0; i < 5; i++)
      chk("t2 source order", (i < out_src.size()) ? out_src[i] : -1, exp2[i]);

    // Backpressure 1,0,0,1 during a packet on port 2
    do_reset();
    push(2, 4, 'h240);
    wait_busy("t3", 50);
    rdy_script = '{1, 0, 0, 1};
    wait_idle("t3", 100);
    chk("t3 beat count", out_data.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("t3 data", (i < out_data.size()) ? out_data[i] : 'hDEAD, 'h240 + i);

    // Late requesters during port 1's packet
    do_reset();
    push(1, 4, 'h140);
    wait_busy("t4", 50);
    push(0, 2, 'h040);
    tick(); tick();
    push(2, 2, 'h240);
    wait_idle("t4", 200);
    chk("t4 packet count", out_src.size(), 3);
    for (int i = 0; i < 3; i++)
      chk("t4 source order", (i < out_src.size()) ? out_src[i] : -1, exp4[i]);

    // Reset in the middle of a 5-beat packet on port 1
    do_reset();
    push(1, 5, 'h150);
    n_wait = 0;
    while (out_data.size() < 2 && n_wait < 50) begin tick(); n_wait++; end
    chk("t5 two beats out", out_data.size() >= 2, 1);
    rst_n = 1'b0;
    beat[1] = 0;
    clear_logs();
    push(1, 5, 'h150);
    void'(q_len[1].pop_back()); void'(q_base[1].pop_back());
    push(0, 2, 'h050);
    tick();
    rst_n = 1'b1;
    chk("t5 m_tvalid after reset", m_tvalid, 0);
    chk("t5 s_tready after reset", s_tready, 0);
    wait_idle("t5", 200);
    chk("t5 first grant", (out_src.size() > 0) ? out_src[0] : -1, 0);
    chk("t5 beats after reset", out_data.size(), 7);

    // Randomized traffic with random valid gaps and backpressure
    do_reset();
    prob = 60;
    rdy_rand = 1'b1;
    for (int k = 0; k < 25; k++)
      for (int p = 0; p < NP; p++)
        push(p, 1 + int'($urandom_range(3)), (p << 8) | ((k % 16) << 4));
    wait_idle("random", 20000);
    chk("random beat total", out_data.size(), tot_beats);
    chk("random packet total", out_src.size(), 100);
    prob = 100;
    rdy_rand = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
